test_scheduler: RTL and testbench

- Sequences a bank of self-checking test instances that share one `clock`; each instance exposes `reset`, `fail` and `finish`.
- Runs the tests one at a time, each from a fresh per-test reset, and bounds every test with a watchdog timeout.
- Stops on the first failure, or after the last test passes.
- Sits between the simulation top and the test instances, and replaces the global `|fail` / `&finish` termination logic with a single `done`/`fail` summary.

---
 rtl/test_scheduler.sv | 165 ++++++++++++++++
 tb/tb_test_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_scheduler.sv
// Runs a bank of self-checking tests one at a time, each behind its own reset and
// watchdog, and condenses their fail/finish flags into a single done/fail summary.
module test_scheduler #(
    parameter int unsigned NUM_TESTS    = 42,
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] test_fail,
    input  logic [NUM_TESTS-1:0] test_finish,
    output logic [NUM_TESTS-1:0] test_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic                 timeout,
    output logic [IDX_W-1:0]     fail_index,
    output logic [IDX_W:0]       pass_count
);

    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_TESTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        FAILED,
        PASSED
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [WD_W-1:0]      wd_cnt, wd_cnt_nxt;
    logic [NUM_TESTS-1:0] test_reset_nxt;
    logic                 busy_nxt, done_nxt, fail_nxt, timeout_nxt;
    logic [IDX_W-1:0]     fail_index_nxt;
    logic [CNT_W-1:0]     pass_count_nxt;

    logic [NUM_TESTS-1:0] sel;
    logic                 cur_fail, cur_finish;

    // Only the selected test's flags are visible to the sequencer.
    assign sel        = NUM_TESTS'(1) << idx;
    assign cur_fail   = |(test_fail & sel);
    assign cur_finish = |(test_finish & sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            wd_cnt     <= '0;
            test_reset <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_index <= '0;
            pass_count <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            hold_cnt   <= hold_cnt_nxt;
            wd_cnt     <= wd_cnt_nxt;
            test_reset <= test_reset_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            fail       <= fail_nxt;
            timeout    <= timeout_nxt;
            fail_index <= fail_index_nxt;
            pass_count <= pass_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        hold_cnt_nxt   = hold_cnt;
        wd_cnt_nxt     = wd_cnt;
        test_reset_nxt = test_reset;
        busy_nxt       = busy;
        done_nxt       = done;
        fail_nxt       = fail;
        timeout_nxt    = timeout;
        fail_index_nxt = fail_index;
        pass_count_nxt = pass_count;

        case (state)
            IDLE, FAILED, PASSED: begin
                // A start from a done state also wipes the previous result.
                if (start) begin
                    state_nxt      = RST_HOLD;
                    idx_nxt        = '0;
                    hold_cnt_nxt   = '0;
                    test_reset_nxt = '1;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    fail_nxt       = 1'b0;
                    timeout_nxt    = 1'b0;
                    fail_index_nxt = '0;
                    pass_count_nxt = '0;
                end
            end

            RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt      = RUN;
                    wd_cnt_nxt     = '0;
                    test_reset_nxt = ~sel;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end

            RUN: begin
                // Fail beats finish, finish beats the watchdog.
                if (cur_fail) begin
                    state_nxt      = FAILED;
                    test_reset_nxt = '1;
                    busy_nxt       = 1'b0;
                    done_nxt       = 1'b1;
                    fail_nxt       = 1'b1;
                    timeout_nxt    = 1'b0;
                    fail_index_nxt = idx;
                end else if (cur_finish) begin
                    test_reset_nxt = '1;
                    pass_count_nxt = pass_count + CNT_W'(1);
                    if (idx == IDX_LAST) begin
                        state_nxt = PASSED;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = RST_HOLD;
                        idx_nxt      = idx + IDX_W'(1);
                        hold_cnt_nxt = '0;
                    end
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt      = FAILED;
                    test_reset_nxt = '1;
                    busy_nxt       = 1'b0;
                    done_nxt       = 1'b1;
                    fail_nxt       = 1'b1;
                    timeout_nxt    = 1'b1;
                    fail_index_nxt = idx;
                end else begin
                    wd_cnt_nxt = wd_cnt + WD_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_test_scheduler.sv
// Bench for test_scheduler: behavioural test instances with random noise on idle
// flags, checked every cycle against a timeline computed from per-test event times.
module tb_test_scheduler;

    localparam int NT = 4;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam int RC = 2;
    localparam int NEVER = 1000000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NT-1:0] tf;
    logic [NT-1:0] tfin;
    logic [NT-1:0] trst;
    logic          busy;
    logic          done;
    logic          fail;
    logic          tmo;
    logic [IW-1:0] fidx;
    logic [IW:0]   pcnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-test behaviour: run cycle (1-based) on which fail pulses / finish rises; 0 = never.
    int fail_at[NT];
    int fin_at[NT];
    int run_cyc[NT];
    bit was_low[NT];

    // Reference timeline, in edges after the edge that sampled start.
    int fall[NT];
    int endc[NT];
    bit passed[NT];
    int last;
    bit exp_fail_out;
    bit exp_tmo;
    int exp_fidx;
    int exp_pass_total;

    test_scheduler #(
        .NUM_TESTS(NT),
        .IDX_W(IW),
        .TIMEOUT(TO),
        .RESET_CYCLES(RC)
    ) dut (
        .clock(clk),
        .reset(rst),
        .start(start),
        .test_fail(tf),
        .test_finish(tfin),
        .test_reset(trst),
        .busy(busy),
        .done(done),
        .fail(fail),
        .timeout(tmo),
        .fail_index(fidx),
        .pass_count(pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each instance reacts to its own reset; idle instances toggle their flags randomly.
    task automatic drive_tests();
        for (int i = 0; i < NT; i++) begin
            if (trst[i] == 1'b0) begin
                run_cyc[i] = was_low[i] ? run_cyc[i] + 1 : 0;
                was_low[i] = 1'b1;
                tf[i]   = (fail_at[i] != 0) && (run_cyc[i] + 1 == fail_at[i]);
                tfin[i] = (fin_at[i] != 0) && (run_cyc[i] + 1 >= fin_at[i]);
            end else begin
                was_low[i] = 1'b0;
                tf[i]   = 1'($urandom);
                tfin[i] = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_tests();
    endtask

    // Walk the tests in order using the suite rules, producing event times.
    task automatic model();
        int t;
        int k;
        t = RC;
        last = NT - 1;
        exp_fail_out = 1'b0;
        exp_tmo = 1'b0;
        exp_fidx = 0;
        exp_pass_total = 0;
        for (int i = 0; i < NT; i++) begin
            fall[i] = NEVER;
            endc[i] = NEVER;
            passed[i] = 1'b0;
        end
        for (int i = 0; i < NT; i++) begin
            fall[i] = t;
            if (fail_at[i] != 0 && fail_at[i] <= TO && (fin_at[i] == 0 || fail_at[i] <= fin_at[i])) begin
                endc[i] = t + fail_at[i];
                last = i;
                exp_fail_out = 1'b1;
                exp_fidx = i;
                break;
            end else if (fin_at[i] != 0 && fin_at[i] <= TO) begin
                k = fin_at[i];
                endc[i] = t + k;
                passed[i] = 1'b1;
                exp_pass_total++;
                t = endc[i] + RC;
            end else begin
                endc[i] = t + TO;
                last = i;
                exp_fail_out = 1'b1;
                exp_tmo = 1'b1;
                exp_fidx = i;
                break;
            end
        end
    endtask

    task automatic check_cycle(input int rel);
        logic [NT-1:0] exp_rst;
        int exp_pc;
        bit exp_busy;
        exp_busy = rel < endc[last];
        exp_pc = 0;
        for (int i = 0; i < NT; i++) begin
            exp_rst[i] = !(rel >= fall[i] && rel < endc[i]);
            if (passed[i] && endc[i] <= rel) exp_pc++;
        end
        chk($sformatf("test_reset@%0d", rel), 32'(trst), 32'(exp_rst));
        chk($sformatf("busy@%0d", rel), 32'(busy), 32'(exp_busy));
        chk($sformatf("done@%0d", rel), 32'(done), 32'(!exp_busy));
        chk($sformatf("fail@%0d", rel), 32'(fail), 32'(!exp_busy && exp_fail_out));
        chk($sformatf("pass_count@%0d", rel), 32'(pcnt), 32'(exp_pc));
    endtask

    // Runs one suite; busy_start_rel injects a stray start, rst_rel aborts with reset.
    task automatic run_suite(input string name, input int busy_start_rel, input int rst_rel);
        int s;
        model();
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        check_cycle(0);
        while (cyc - s < endc[last] + 3) begin
            if (cyc - s == busy_start_rel) start = 1'b1;
            if (cyc - s == rst_rel) rst = 1'b1;
            step();
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                chk({name, ":rst test_reset"}, 32'(trst), 32'hF);
                chk({name, ":rst busy"}, 32'(busy), 32'd0);
                chk({name, ":rst done"}, 32'(done), 32'd0);
                chk({name, ":rst pass_count"}, 32'(pcnt), 32'd0);
                return;
            end
            check_cycle(cyc - s);
        end
        chk({name, ":fail"}, 32'(fail), 32'(exp_fail_out));
        chk({name, ":pass_count"}, 32'(pcnt), 32'(exp_pass_total));
        if (exp_fail_out) begin
            chk({name, ":timeout"}, 32'(tmo), 32'(exp_tmo));
            chk({name, ":fail_index"}, 32'(fidx), 32'(exp_fidx));
        end
    endtask

    task automatic set_all(input int fa, input int fi);
        for (int i = 0; i < NT; i++) begin
            fail_at[i] = fa;
            fin_at[i] = fi;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tf = '0;
        tfin = '0;
        set_all(0, 3);
        for (int i = 0; i < NT; i++) begin
            run_cyc[i] = 0;
            was_low[i] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        chk("reset test_reset", 32'(trst), 32'hF);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset fail", 32'(fail), 32'd0);
        chk("reset timeout", 32'(tmo), 32'd0);
        chk("reset fail_index", 32'(fidx), 32'd0);
        chk("reset pass_count", 32'(pcnt), 32'd0);
        step();
        step();
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle test_reset", 32'(trst), 32'hF);

        set_all(0, 3);
        run_suite("all_pass", -1, -1);

        set_all(0, 3);
        fin_at[2] = 0;
        fail_at[2] = 5;
        run_suite("fail_t2", -1, -1);

        set_all(0, 3);
        fin_at[1] = 0;
        run_suite("timeout_t1", -1, -1);

        set_all(0, 3);
        fail_at[0] = 2;
        fin_at[0] = 2;
        run_suite("fail_finish_t0", -1, -1);

        set_all(0, 3);
        run_suite("reset_mid_t1", -1, 2 * RC + 3 + 1);
        run_suite("rerun_after_reset", -1, -1);

        set_all(0, 3);
        fail_at[1] = 3;
        fin_at[1] = 0;
        run_suite("fail_t1", -1, -1);
        set_all(0, 3);
        run_suite("rerun_busy_start", 1, -1);

        set_all(0, 1);
        fin_at[3] = TO;
        run_suite("finish_at_release_last_chance", -1, -1);
        set_all(0, 1);
        fin_at[3] = TO + 1;
        run_suite("finish_one_late", -1, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NT; i++) begin
                fin_at[i] = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, TO + 2));
                fail_at[i] = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, TO + 2)) : 0;
            end
            run_suite($sformatf("random%0d", r), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
